parity_tx: RTL and testbench

PARITY_TX -- requirements
Module: parity_tx

---
 rtl/parity_pkg.sv | 19 +
 rtl/parity_tx_if.sv | 37 +++
 rtl/parity_tx.sv | 101 ++++++++++
 tb/tb_parity_tx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity transmitter and receiver.
`timescale 1ns/1ps
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Seed value of the running parity for a given parity sense.
  function automatic logic par_init(input int odd);
    return (odd != 0) ? PAR_ODD : PAR_EVEN;
  endfunction

endpackage

// File: rtl/parity_tx_if.sv
// Word-in / bit-out handshake bundle of the parity transmitter.
`timescale 1ns/1ps
interface parity_tx_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             tx_ready;
  logic             tx_bit;
  logic             tx_valid;
  logic             tx_last;

  // Transmitter side.
  modport slave (
    input  in_data,
    input  in_valid,
    input  tx_ready,
    output in_ready,
    output tx_bit,
    output tx_valid,
    output tx_last
  );

  // Word producer / serial consumer side.
  modport master (
    output in_data,
    output in_valid,
    output tx_ready,
    input  in_ready,
    input  tx_bit,
    input  tx_valid,
    input  tx_last
  );

endinterface

// File: rtl/parity_tx.sv
// Parallel-to-serial transmitter: sends a word LSB first followed by
// one parity bit. A new word can be taken while the parity bit leaves,
// so consecutive frames run without idle cycles.
`timescale 1ns/1ps
module parity_tx
  import parity_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ODD   = 0
) (
  input  logic        clock,
  input  logic        reset,
  parity_tx_if.slave  bus
);

  localparam int   CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic PAR_SEED = par_init(ODD);

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg, sreg_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             par, par_nx;
  logic             in_ready;
  logic             tx_valid;
  logic             tx_last;
  logic             tx_bit;

  // State register; reset aborts any frame in flight immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      par   <= PAR_SEED;
    end else begin
      state <= state_nx;
      sreg  <= sreg_nx;
      cnt   <= cnt_nx;
      par   <= par_nx;
    end
  end

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_nx = state;
    sreg_nx  = sreg;
    cnt_nx   = cnt;
    par_nx   = par;
    in_ready = 1'b0;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_bit   = 1'b0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
      end
      DATA: begin
        tx_valid = 1'b1;
        tx_bit   = sreg[0];
        if (bus.tx_ready) begin
          sreg_nx = sreg >> 1;
          par_nx  = par ^ sreg[0];
          // The counter stops at the last bit instead of wrapping.
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state_nx = PAR;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      PAR: begin
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        tx_bit   = par;
        // The slot frees up on the same edge the parity bit is taken.
        in_ready = bus.tx_ready;
        if (bus.tx_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    // A fresh word overrides the IDLE/PAR exit above.
    if (bus.in_valid && in_ready) begin
      sreg_nx  = bus.in_data;
      cnt_nx   = '0;
      par_nx   = PAR_SEED;
      state_nx = DATA;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.tx_valid = tx_valid;
  assign bus.tx_last  = tx_last;
  assign bus.tx_bit   = tx_bit;

endmodule

// File: tb/tb_parity_tx.sv
// Bench for parity_tx: an even-parity and an odd-parity instance share
// the same stimulus; a frame-level model predicts every serial beat.
`timescale 1ns/1ps
module tb_parity_tx;
  import parity_pkg::*;

  localparam int W = 8;

  logic         clock    = 1'b0;
  logic         reset    = 1'b0;
  logic [W-1:0] in_data  = '0;
  logic         in_valid = 1'b0;
  logic         tx_ready = 1'b0;

  always #5 clock = ~clock;

  parity_tx_if #(.WIDTH(W)) if_e ();
  parity_tx_if #(.WIDTH(W)) if_o ();

  assign if_e.in_data  = in_data;
  assign if_e.in_valid = in_valid;
  assign if_e.tx_ready = tx_ready;
  assign if_o.in_data  = in_data;
  assign if_o.in_valid = in_valid;
  assign if_o.tx_ready = tx_ready;

  parity_tx #(.WIDTH(W), .ODD(int'(PAR_EVEN))) dut_e (
    .clock (clock),
    .reset (reset),
    .bus   (if_e)
  );

  parity_tx #(.WIDTH(W), .ODD(int'(PAR_ODD))) dut_o (
    .clock (clock),
    .reset (reset),
    .bus   (if_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: each accepted word becomes a list of {last, bit} beats.
  bit [1:0] exp_q   [2][$];
  bit       par_log [2][$];
  bit       bit_log_e [$];
  int       beats_e = 0;
  int       lasts_e = 0;
  int       idle_e  = 0;

  task automatic score(input int k, input logic v, input logic b, input logic l, input logic ir);
    string    p;
    bit       busy;
    bit       exp_ir;
    bit [1:0] h;
    p = (k == 1) ? "o_" : "e_";
    if (!reset) begin
      exp_q[k].delete();
      check_eq({p, "rst_valid"}, v, 0);
      check_eq({p, "rst_last"}, l, 0);
      check_eq({p, "rst_bit"}, b, 0);
      check_eq({p, "rst_in_ready"}, ir, 1);
      return;
    end
    busy   = exp_q[k].size() != 0;
    h      = busy ? exp_q[k][0] : 2'b00;
    exp_ir = !busy || (h[1] && tx_ready);
    check_eq({p, "valid"}, v, busy);
    check_eq({p, "in_ready"}, ir, exp_ir);
    check_eq({p, "bit"}, b, h[0]);
    check_eq({p, "last"}, l, h[1]);
    if (v && l && tx_ready) par_log[k].push_back(b);
    if (busy && tx_ready) void'(exp_q[k].pop_front());
    if (in_valid && exp_ir) begin
      for (int i = 0; i < W; i++) exp_q[k].push_back({1'b0, in_data[i]});
      exp_q[k].push_back({1'b1, (^in_data) ^ (k == 1)});
    end
  endtask

  // Sample both instances away from the active edge.
  always @(negedge clock) begin
    score(0, if_e.tx_valid, if_e.tx_bit, if_e.tx_last, if_e.in_ready);
    score(1, if_o.tx_valid, if_o.tx_bit, if_o.tx_last, if_o.in_ready);
    if (reset) begin
      if (!if_e.tx_valid) idle_e++;
      if (if_e.tx_valid && tx_ready) begin
        beats_e++;
        bit_log_e.push_back(if_e.tx_bit);
        if (if_e.tx_last) lasts_e++;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w, output int waited);
    in_valid = 1'b1;
    in_data  = w;
    waited   = 0;
    @(negedge clock);
    while (!if_e.in_ready && waited < 200) begin
      waited++;
      @(negedge clock);
    end
    check_eq("accept", if_e.in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_data  = W'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while ((if_e.tx_valid || if_o.tx_valid) && n < 300) begin
      n++;
      @(negedge clock);
    end
    check_eq("idle_e", if_e.tx_valid, 0);
    check_eq("idle_o", if_o.tx_valid, 0);
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int           w;
    int           b0;
    int           l0;
    int           i0;
    int           n;
    logic [8:0]   seq;

    // Reset state.
    repeat (3) @(negedge clock);
    check_eq("rst_e_in_ready", if_e.in_ready, 1);
    check_eq("rst_o_valid", if_o.tx_valid, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    tx_ready = 1'b1;

    // 0xA5 even parity, exact bit sequence, first edge after release.
    b0 = beats_e;
    send(8'hA5, w);
    check_eq("first_accept_wait", w, 0);
    wait_idle();
    check_eq("a5_beats", beats_e - b0, 9);
    seq = 9'h0A5;
    for (int i = 0; i < 9; i++) check_eq($sformatf("a5_seq%0d", i), bit_log_e[b0 + i], seq[i]);
    check_eq("a5_par_e", par_log[0][$], 0);
    check_eq("a5_par_o", par_log[1][$], 1);

    // All-zero and 0x07 parity.
    send(8'h00, w);
    wait_idle();
    check_eq("z_par_e", par_log[0][$], 0);
    check_eq("z_par_o", par_log[1][$], 1);
    send(8'h07, w);
    wait_idle();
    check_eq("s7_par_e", par_log[0][$], 1);
    check_eq("s7_par_o", par_log[1][$], 0);

    // 0x3C stalled for three cycles on bit 4.
    b0 = beats_e;
    send(8'h3C, w);
    repeat (4) tick();
    tx_ready = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check_eq("stall_bit", if_e.tx_bit, 1);
      check_eq("stall_valid", if_e.tx_valid, 1);
      tick();
    end
    tx_ready = 1'b1;
    wait_idle();
    check_eq("3c_beats", beats_e - b0, 9);
    check_eq("3c_par_e", par_log[0][$], 0);

    // 0x01 then 0xFF with in_valid held high: no gap between frames.
    b0 = beats_e;
    l0 = lasts_e;
    in_valid = 1'b1;
    in_data  = 8'h01;
    n = 0;
    @(negedge clock);
    while (!if_e.in_ready && n < 50) begin n++; @(negedge clock); end
    tick();
    i0 = idle_e;
    in_data = 8'hFF;
    n = 0;
    @(negedge clock);
    while (!if_e.in_ready && n < 50) begin n++; @(negedge clock); end
    check_eq("b2b_on_par", if_e.tx_last, 1);
    tick();
    in_valid = 1'b0;
    check_eq("b2b_gap", idle_e - i0, 0);
    check_eq("b2b_next_valid", if_e.tx_valid, 1);
    wait_idle();
    check_eq("b2b_lasts", lasts_e - l0, 2);
    check_eq("b2b_beats", beats_e - b0, 18);
    check_eq("b2b_par1", par_log[0][par_log[0].size() - 2], 1);
    check_eq("b2b_par2", par_log[0][$], 0);

    // Reset in the middle of 0xAA, then a clean 0x80 frame.
    send(8'hAA, w);
    repeat (5) tick();
    #2 reset = 1'b0;
    #1;
    check_eq("mid_rst_valid_e", if_e.tx_valid, 0);
    check_eq("mid_rst_in_ready_e", if_e.in_ready, 1);
    check_eq("mid_rst_valid_o", if_o.tx_valid, 0);
    check_eq("mid_rst_last_e", if_e.tx_last, 0);
    @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    b0 = beats_e;
    send(8'h80, w);
    check_eq("post_rst_wait", w, 0);
    wait_idle();
    check_eq("80_beats", beats_e - b0, 9);
    check_eq("80_par_e", par_log[0][$], 1);
    check_eq("80_par_o", par_log[1][$], 0);

    // Offered words during DATA are refused and do not disturb the frame.
    send(8'h5A, w);
    repeat (4) begin
      in_valid = 1'b1;
      in_data  = W'($urandom);
      @(negedge clock);
      check_eq("busy_in_ready", if_e.in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    wait_idle();

    // Randomized traffic with random back-pressure.
    repeat (1500) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = W'($urandom);
      tx_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    tx_ready = 1'b1;
    wait_idle();
    check_eq("drain_e", exp_q[0].size(), 0);
    check_eq("drain_o", exp_q[1].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
